// File: rtl/march_pkg.sv
// march_pkg: shared constants, FSM state encoding and fixed-point helpers
// for the sphere-tracing core (march_engine / sphere_sdf_eval).
// The helpers work in a 64-bit signed domain so that modules with any
// BITS <= 64 can sign-extend into them and truncate the result back.
package march_pkg;

  localparam int DEF_BITS  = 32;
  localparam int DEF_FIXED = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_EVAL, S_STEP, S_HIT, S_MAXSTEP, S_MISS, S_RESULT
  } state_t;

  localparam logic [23:0] RGB_MAXSTEP = 24'hFF0000;
  localparam logic [23:0] RGB_BG      = 24'hFFFFFF;
  localparam logic [23:0] RGB_CHECK   = 24'hFFFF00;

  // Truncating fixed-point multiply: (a*b) >>> fx.
  function automatic logic signed [63:0] qmult(input logic signed [63:0] a,
                                               input logic signed [63:0] b,
                                               input int fx);
    logic signed [127:0] p;
    p = 128'(a) * 128'(b);
    return 64'(p >>> fx);
  endfunction

  // Full-precision square; always non-negative.
  function automatic logic [127:0] sq(input logic signed [63:0] a);
    logic signed [127:0] w;
    w = 128'(a);
    return $unsigned(w * w);
  endfunction

  // Clamp a non-negative value to the largest positive 'bits'-wide signed word.
  function automatic logic [63:0] sat_pos(input logic [127:0] x, input int bits);
    logic [63:0] mx;
    mx = (64'(1) << (bits - 1)) - 64'(1);
    return (x > {64'b0, mx}) ? mx : x[63:0];
  endfunction

endpackage

// File: rtl/sphere_sdf_eval.sv
// sphere_sdf_eval: signed distance from a point to one sphere.
//   d = sqrt(sat(|p-c|^2)) - r, all values Q(BITS-FIXED).FIXED.
// One evaluation per 'start' pulse; 'valid' pulses once when 'd' is ready.
// The square root is bit-serial (two radicand bits per cycle), so latency
// is (BITS+FIXED)/2 + 1 cycles from start.
// Ports: clk/rst_n, start, pos_x/y/z, cx/cy/cz, r (inputs sampled on start),
//        valid (1-cycle pulse), d (signed distance, held until next result).
module sphere_sdf_eval
  import march_pkg::*;
#(
  parameter int BITS  = DEF_BITS,
  parameter int FIXED = DEF_FIXED
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic signed [BITS-1:0] pos_x,
  input  logic signed [BITS-1:0] pos_y,
  input  logic signed [BITS-1:0] pos_z,
  input  logic signed [BITS-1:0] cx,
  input  logic signed [BITS-1:0] cy,
  input  logic signed [BITS-1:0] cz,
  input  logic signed [BITS-1:0] r,
  output logic                   valid,
  output logic signed [BITS-1:0] d
);
  localparam int RADW  = BITS + FIXED;   // radicand = sat << FIXED keeps Q format
  localparam int ROOTW = RADW / 2;
  localparam int CW    = $clog2(ROOTW + 1);

  // One extra bit so the difference itself never wraps.
  logic signed [BITS:0] dx, dy, dz;
  logic [127:0]         dist_sq;
  logic [BITS-1:0]      dist_sat;

  assign dx       = (BITS+1)'(pos_x) - (BITS+1)'(cx);
  assign dy       = (BITS+1)'(pos_y) - (BITS+1)'(cy);
  assign dz       = (BITS+1)'(pos_z) - (BITS+1)'(cz);
  assign dist_sq  = sq(64'(dx)) + sq(64'(dy)) + sq(64'(dz));
  assign dist_sat = BITS'(sat_pos(dist_sq >> FIXED, BITS));

  logic [RADW-1:0]   rad;
  logic [ROOTW-1:0]  rem, root, root_nx;
  logic [ROOTW+1:0]  rem_sh, trial;
  logic [CW-1:0]     cnt;
  logic              busy;
  logic signed [BITS-1:0] r_q;

  // Restoring sqrt step. Before the final step rem < 2^ROOTW, so ROOTW bits
  // of stored remainder are enough; the last remainder is never reused.
  assign rem_sh  = {rem, rad[RADW-1 -: 2]};
  assign trial   = {root, 2'b01};
  assign root_nx = {root[ROOTW-2:0], (rem_sh >= trial)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad <= '0; rem <= '0; root <= '0; cnt <= '0;
      busy <= 1'b0; valid <= 1'b0; d <= '0; r_q <= '0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        rad  <= {dist_sat, {FIXED{1'b0}}};
        rem  <= '0;
        root <= '0;
        cnt  <= CW'(ROOTW);
        r_q  <= r;
        busy <= 1'b1;
      end else if (busy) begin
        rem  <= (rem_sh >= trial) ? ROOTW'(rem_sh - trial) : ROOTW'(rem_sh);
        root <= root_nx;
        rad  <= rad << 2;
        cnt  <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy  <= 1'b0;
          valid <= 1'b1;
          d     <= $signed(BITS'(root_nx)) - r_q;
        end
      end
    end
  end

endmodule

// File: rtl/march_engine.sv
// march_engine: sphere-tracing core. Marches one unit-direction ray per
// request through a loadable table of NUM_SPHERES spheres and returns a
// shaded colour, hit flag and step count with the echoed pixel tag.
// Ports: clk_in/rst_n_in; req_valid_in/req_ready_out with req_x_in/req_y_in
//   and dir_x_in/dir_y_in/dir_z_in; scene write port sph_we_in, sph_idx_in,
//   sph_cx_in/cy/cz, sph_r_in, sph_rgb_in, sph_en_in (honoured only in IDLE);
//   result port res_valid_out/res_ready_in with red/green/blue_out,
//   out_x/out_y, res_hit_out, res_steps_out.
// Build option: MARCH_CHECKER_BG_EN selects a checkerboard miss background
//   ({FF,FF,00} on alternate 16-pixel tiles) instead of plain white.
module march_engine
  import march_pkg::*;
#(
  parameter int     BITS        = DEF_BITS,
  parameter int     FIXED       = DEF_FIXED,
  parameter int     NUM_SPHERES = 4,
  parameter int     MAX_STEPS   = 100,
  parameter longint MAX_DIST_SQ = 64'sd1 << 30,
  parameter int     EPSILON     = 1 << (FIXED - 4),
  parameter int     XW          = 11,
  parameter int     YW          = 10,
  localparam int    IW = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1,
  localparam int    SW = (MAX_STEPS > 0) ? $clog2(MAX_STEPS + 1) : 1
)(
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   req_valid_in,
  output logic                   req_ready_out,
  input  logic [XW-1:0]          req_x_in,
  input  logic [YW-1:0]          req_y_in,
  input  logic signed [BITS-1:0] dir_x_in,
  input  logic signed [BITS-1:0] dir_y_in,
  input  logic signed [BITS-1:0] dir_z_in,
  input  logic                   sph_we_in,
  input  logic [IW-1:0]          sph_idx_in,
  input  logic signed [BITS-1:0] sph_cx_in,
  input  logic signed [BITS-1:0] sph_cy_in,
  input  logic signed [BITS-1:0] sph_cz_in,
  input  logic signed [BITS-1:0] sph_r_in,
  input  logic [23:0]            sph_rgb_in,
  input  logic                   sph_en_in,
  output logic                   res_valid_out,
  input  logic                   res_ready_in,
  output logic [7:0]             red_out,
  output logic [7:0]             green_out,
  output logic [7:0]             blue_out,
  output logic [XW-1:0]          out_x,
  output logic [YW-1:0]          out_y,
  output logic                   res_hit_out,
  output logic [SW-1:0]          res_steps_out
);
  typedef struct packed {
    logic                   en;
    logic [23:0]            rgb;
    logic signed [BITS-1:0] cx, cy, cz, r;
  } sph_t;

  localparam logic signed [BITS-1:0] D_MAX = {1'b0, {(BITS-1){1'b1}}};
  localparam logic signed [BITS-1:0] EPS   = BITS'(EPSILON);

  state_t state, state_n;
  sph_t   scene [NUM_SPHERES];

  logic signed [BITS-1:0] pos_x, pos_y, pos_z, dir_x, dir_y, dir_z, dmin, dmin_nx;
  logic [XW-1:0] tag_x;
  logic [YW-1:0] tag_y;
  logic [SW-1:0] steps;
  logic [IW-1:0] idx, arg;
  logic          ev_busy, sdf_start, sdf_valid, cand_take, upd, advance, last;
  logic signed [BITS-1:0] sdf_d;
  logic [127:0]  pos_sq;
  logic [23:0]   bg, hit_rgb;

  assign sdf_start = (state == S_EVAL) && !ev_busy && scene[idx].en;
  assign cand_take = ev_busy && sdf_valid;
  assign upd       = cand_take && (sdf_d < dmin);   // strict: ties keep lower index
  assign dmin_nx   = upd ? sdf_d : dmin;
  assign advance   = (state == S_EVAL) && ((!ev_busy && !scene[idx].en) || cand_take);
  assign last      = (idx == IW'(NUM_SPHERES - 1));
  assign pos_sq    = sq(64'(pos_x)) + sq(64'(pos_y)) + sq(64'(pos_z));
  assign hit_rgb   = scene[arg].rgb;

`ifdef MARCH_CHECKER_BG_EN
  assign bg = (tag_x[4] ^ tag_y[4]) ? RGB_BG : RGB_CHECK;
`else
  assign bg = RGB_BG;
`endif

  sphere_sdf_eval #(.BITS(BITS), .FIXED(FIXED)) u_sdf (
    .clk(clk_in), .rst_n(rst_n_in), .start(sdf_start),
    .pos_x(pos_x), .pos_y(pos_y), .pos_z(pos_z),
    .cx(scene[idx].cx), .cy(scene[idx].cy), .cz(scene[idx].cz), .r(scene[idx].r),
    .valid(sdf_valid), .d(sdf_d)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= S_IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (req_valid_in && req_ready_out) state_n = S_EVAL;
      S_EVAL:   if (advance && last) state_n = (dmin_nx < EPS) ? S_HIT : S_STEP;
      S_STEP: begin
        if (steps == SW'(MAX_STEPS))                   state_n = S_MAXSTEP;
        else if ((pos_sq >> FIXED) > 128'(MAX_DIST_SQ)) state_n = S_MISS;
        else                                           state_n = S_EVAL;
      end
      S_HIT, S_MAXSTEP, S_MISS: state_n = S_RESULT;
      S_RESULT: if (res_valid_out && res_ready_in) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_SPHERES; i++) scene[i] <= '0;
      {pos_x, pos_y, pos_z, dir_x, dir_y, dir_z} <= '0;
      dmin <= '0; tag_x <= '0; tag_y <= '0; steps <= '0;
      idx <= '0; arg <= '0; ev_busy <= 1'b0;
      req_ready_out <= 1'b0; res_valid_out <= 1'b0;
      red_out <= '0; green_out <= '0; blue_out <= '0;
      out_x <= '0; out_y <= '0; res_hit_out <= 1'b0; res_steps_out <= '0;
    end else begin
      req_ready_out <= (state_n == S_IDLE);
      case (state)
        S_IDLE: begin
          if (sph_we_in && (int'(sph_idx_in) < NUM_SPHERES))
            scene[sph_idx_in] <= '{en: sph_en_in, rgb: sph_rgb_in, cx: sph_cx_in,
                                   cy: sph_cy_in, cz: sph_cz_in, r: sph_r_in};
          if (req_valid_in && req_ready_out) begin
            dir_x <= dir_x_in; dir_y <= dir_y_in; dir_z <= dir_z_in;
            tag_x <= req_x_in; tag_y <= req_y_in;
            {pos_x, pos_y, pos_z} <= '0;
            steps <= '0; dmin <= D_MAX; idx <= '0; arg <= '0; ev_busy <= 1'b0;
          end
        end
        S_EVAL: begin
          if (sdf_start) ev_busy <= 1'b1;
          if (cand_take) begin
            ev_busy <= 1'b0;
            dmin    <= dmin_nx;
            if (upd) arg <= idx;
          end
          if (advance) idx <= last ? '0 : idx + IW'(1);
        end
        S_STEP: begin
          if (state_n == S_EVAL) begin
            pos_x <= pos_x + BITS'(qmult(64'(dir_x), 64'(dmin), FIXED));
            pos_y <= pos_y + BITS'(qmult(64'(dir_y), 64'(dmin), FIXED));
            pos_z <= pos_z + BITS'(qmult(64'(dir_z), 64'(dmin), FIXED));
            steps <= steps + SW'(1);
            dmin  <= D_MAX;
          end
        end
        S_HIT, S_MAXSTEP, S_MISS: begin
          res_valid_out <= 1'b1;
          res_hit_out   <= (state == S_HIT);
          res_steps_out <= steps;
          out_x <= tag_x; out_y <= tag_y;
          if (state == S_HIT) begin
            // Darken with depth: halve per two steps taken.
            red_out   <= hit_rgb[23:16] >> (steps >> 1);
            green_out <= hit_rgb[15:8]  >> (steps >> 1);
            blue_out  <= hit_rgb[7:0]   >> (steps >> 1);
          end else begin
            {red_out, green_out, blue_out} <= (state == S_MAXSTEP) ? RGB_MAXSTEP : bg;
          end
        end
        S_RESULT: if (res_valid_out && res_ready_in) res_valid_out <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_march_engine.sv
// Directed bench for march_engine: one default instance and one with
// MAX_STEPS=0 sharing clock, reset, scene port and result-ready.
module tb_march_engine;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_valid0 = 1'b0, res_ready = 1'b1;
  logic [10:0] req_x = '0;
  logic [9:0]  req_y = '0;
  logic signed [31:0] dir_x = '0, dir_y = '0, dir_z = '0;
  logic sph_we = 1'b0, sph_en = 1'b0;
  logic [1:0] sph_idx = '0;
  logic signed [31:0] sph_cx = '0, sph_cy = '0, sph_cz = '0, sph_r = '0;
  logic [23:0] sph_rgb = '0;

  logic req_ready, res_valid, hit;
  logic [7:0] red, green, blue;
  logic [10:0] ox;
  logic [9:0] oy;
  logic [6:0] steps;
  logic req_ready0, res_valid0, hit0;
  logic [7:0] red0, green0, blue0;
  logic [10:0] ox0;
  logic [9:0] oy0;
  logic [0:0] steps0;

  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  march_engine dut (
    .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(req_valid), .req_ready_out(req_ready),
    .req_x_in(req_x), .req_y_in(req_y), .dir_x_in(dir_x), .dir_y_in(dir_y), .dir_z_in(dir_z),
    .sph_we_in(sph_we), .sph_idx_in(sph_idx), .sph_cx_in(sph_cx), .sph_cy_in(sph_cy),
    .sph_cz_in(sph_cz), .sph_r_in(sph_r), .sph_rgb_in(sph_rgb), .sph_en_in(sph_en),
    .res_valid_out(res_valid), .res_ready_in(res_ready), .red_out(red), .green_out(green),
    .blue_out(blue), .out_x(ox), .out_y(oy), .res_hit_out(hit), .res_steps_out(steps)
  );

  march_engine #(.MAX_STEPS(0)) dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(req_valid0), .req_ready_out(req_ready0),
    .req_x_in(req_x), .req_y_in(req_y), .dir_x_in(dir_x), .dir_y_in(dir_y), .dir_z_in(dir_z),
    .sph_we_in(sph_we), .sph_idx_in(sph_idx), .sph_cx_in(sph_cx), .sph_cy_in(sph_cy),
    .sph_cz_in(sph_cz), .sph_r_in(sph_r), .sph_rgb_in(sph_rgb), .sph_en_in(sph_en),
    .res_valid_out(res_valid0), .res_ready_in(res_ready), .red_out(red0), .green_out(green0),
    .blue_out(blue0), .out_x(ox0), .out_y(oy0), .res_hit_out(hit0), .res_steps_out(steps0)
  );

  task automatic write_sph(input logic [1:0] i, input int cz, input int r,
                           input logic [23:0] rgb, input logic en);
    sph_idx = i; sph_cx = 0; sph_cy = 0; sph_cz = cz <<< 16; sph_r = r <<< 16;
    sph_rgb = rgb; sph_en = en; sph_we = 1'b1;
    @(negedge clk); sph_we = 1'b0;
  endtask

  // Waits for the selected instance to be ready, then presents one request.
  task automatic fire(input int which, input logic [10:0] x, input logic [9:0] y,
                      input int dx, input int dy, input int dz);
    int n = 0;
    while (((which == 0) ? req_ready : req_ready0) !== 1'b1 && n < 300) begin
      @(negedge clk); n++;
    end
    if (n >= 300) begin nvec++; nerr++; $display("FAIL accept_timeout got busy want ready"); end
    req_x = x; req_y = y; dir_x = dx <<< 16; dir_y = dy <<< 16; dir_z = dz <<< 16;
    if (which == 0) req_valid = 1'b1; else req_valid0 = 1'b1;
    @(negedge clk); req_valid = 1'b0; req_valid0 = 1'b0;
  endtask

  task automatic wait_res(input int which);
    int n = 0;
    while (((which == 0) ? res_valid : res_valid0) !== 1'b1 && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) begin nvec++; nerr++; $display("FAIL result_timeout got no valid want valid"); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #3;
    nvec++; if (res_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid got %b want 0", res_valid); end
    nvec++; if ({red, green, blue, hit, steps} !== '0) begin nerr++; $display("FAIL rst_outs got %h want 0", {red, green, blue, hit, steps}); end
    nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL rst_ready got %b want 0", req_ready); end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready_after got %b want 1", req_ready); end
  endtask

  task automatic test_hit();
    write_sph(2'd0, 150, 32, 24'hF00000, 1'b1);
    fire(0, 11'd123, 10'd45, 0, 0, 1); wait_res(0);
    nvec++; if (hit !== 1'b1) begin nerr++; $display("FAIL hit_flag got %b want 1", hit); end
    nvec++; if (steps !== 7'd1) begin nerr++; $display("FAIL hit_steps got %0d want 1", steps); end
    nvec++; if ({red, green, blue} !== 24'hF00000) begin nerr++; $display("FAIL hit_rgb got %h want F00000", {red, green, blue}); end
    nvec++; if (ox !== 11'd123 || oy !== 10'd45) begin nerr++; $display("FAIL hit_tag got %0d,%0d want 123,45", ox, oy); end
    @(negedge clk);
  endtask

  task automatic test_miss();
    fire(0, 11'd3, 10'd5, 0, 1, 0); wait_res(0);
    nvec++; if (hit !== 1'b0) begin nerr++; $display("FAIL miss_flag got %b want 0", hit); end
    nvec++; if (steps !== 7'd2) begin nerr++; $display("FAIL miss_steps got %0d want 2", steps); end
    nvec++; if ({red, green, blue} !== 24'hFFFFFF) begin nerr++; $display("FAIL miss_rgb got %h want FFFFFF", {red, green, blue}); end
    @(negedge clk);
  endtask

  task automatic test_maxstep();
    fire(1, 11'd9, 10'd9, 0, 1, 0); wait_res(1);
    nvec++; if (hit0 !== 1'b0) begin nerr++; $display("FAIL max_flag got %b want 0", hit0); end
    nvec++; if (steps0 !== 1'b0) begin nerr++; $display("FAIL max_steps got %0d want 0", steps0); end
    nvec++; if ({red0, green0, blue0} !== 24'hFF0000) begin nerr++; $display("FAIL max_rgb got %h want FF0000", {red0, green0, blue0}); end
    @(negedge clk);
  endtask

  task automatic test_hold();
    res_ready = 1'b0;
    fire(0, 11'd7, 10'd9, 0, 0, 1); wait_res(0);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        sph_idx = 2'd0; sph_rgb = 24'h00FF00; sph_r = 32'sd5 <<< 16; sph_en = 1'b1; sph_we = 1'b1;
      end else sph_we = 1'b0;
      nvec++; if (res_valid !== 1'b1) begin nerr++; $display("FAIL hold_valid c%0d got %b want 1", i, res_valid); end
      nvec++; if ({red, green, blue} !== 24'hF00000 || steps !== 7'd1) begin nerr++; $display("FAIL hold_data c%0d got %h/%0d want F00000/1", i, {red, green, blue}, steps); end
      nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL hold_ready c%0d got %b want 0", i, req_ready); end
      @(negedge clk);
    end
    sph_we = 1'b0; res_ready = 1'b1; @(negedge clk);
    nvec++; if (res_valid !== 1'b0) begin nerr++; $display("FAIL hold_release got %b want 0", res_valid); end
    nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL hold_ready_after got %b want 1", req_ready); end
    fire(0, 11'd8, 10'd1, 0, 0, 1); wait_res(0);
    nvec++; if (hit !== 1'b1 || steps !== 7'd1 || {red, green, blue} !== 24'hF00000) begin
      nerr++; $display("FAIL hold_rerun got %b/%0d/%h want 1/1/F00000", hit, steps, {red, green, blue}); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    fire(0, 11'd100, 10'd100, 0, 0, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0; #1;
    nvec++; if ({res_valid, red, green, blue, hit, steps, ox, oy} !== '0) begin
      nerr++; $display("FAIL midrst_outs got %h want 0", {res_valid, red, green, blue, hit, steps, ox, oy}); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (res_valid !== 1'b0) begin nvec++; nerr++; $display("FAIL midrst_result got %b want 0", res_valid); end
      @(negedge clk);
    end
    nvec++;
    // Scene is cleared: with no sphere the ray escapes after one full step.
    fire(0, 11'd0, 10'd0, 0, 1, 0); wait_res(0);
    nvec++; if (hit !== 1'b0 || steps !== 7'd1) begin nerr++; $display("FAIL midrst_scene got %b/%0d want 0/1", hit, steps); end
    nvec++; if ({red, green, blue} !== 24'hFFFFFF) begin nerr++; $display("FAIL midrst_rgb got %h want FFFFFF", {red, green, blue}); end
    @(negedge clk);
  endtask

  task automatic test_checker();
    logic [23:0] exp16;
`ifdef MARCH_CHECKER_BG_EN
    exp16 = 24'hFFFF00;
`else
    exp16 = 24'hFFFFFF;
`endif
    fire(0, 11'd16, 10'd0, 0, 1, 0); wait_res(0);
    nvec++; if ({red, green, blue} !== 24'hFFFFFF) begin nerr++; $display("FAIL bg_16_0 got %h want FFFFFF", {red, green, blue}); end
    @(negedge clk);
    fire(0, 11'd16, 10'd16, 0, 1, 0); wait_res(0);
    nvec++; if ({red, green, blue} !== exp16) begin nerr++; $display("FAIL bg_16_16 got %h want %h", {red, green, blue}, exp16); end
    nvec++; if (ox !== 11'd16 || oy !== 10'd16) begin nerr++; $display("FAIL bg_tag got %0d,%0d want 16,16", ox, oy); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_maxstep();
    test_hold();
    test_reset_mid();
    test_checker();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
